// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - fetch_state_t : fetch controller states (IDLE, RUN, HALT)
//   - FETCH_AW/DW   : default PC width and instruction width
//   - NOP_WORD      : the all-zero word that halts fetch when enabled
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int FETCH_AW = 8;
  localparam int FETCH_DW = 32;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   IF/ID handshake between the fetch stage (master) and decode (slave).
//   - id_valid   : IF/ID register holds an instruction
//   - id_ready   : decode accepts IF/ID this cycle
//   - id_instr   : captured instruction word
//   - id_pc      : word address the instruction came from
//   - id_pc_next : id_pc + 1, wrapping
interface fetch_stage_if #(
  parameter int AW = 8,
  parameter int DW = 32
) ();

  logic          id_valid;
  logic          id_ready;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_pc_next;

  modport master (
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_next,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_next,
    output id_ready
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg
//   Program counter register with its next-PC mux.
//   Priority: rst > redirect > advance (+1, wrapping) > hold.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     redirect      : load redirect_pc
//     redirect_pc   : redirect target word address
//     advance       : step to pc + 1 (wraps at 2^AW)
//     pc            : current program counter
module pc_reg #(
  parameter int AW       = 8,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          advance,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_value_reg;
  logic [AW-1:0] pc_value_next;

  always_comb begin
    pc_value_next = pc_value_reg;
    if (redirect) begin
      pc_value_next = redirect_pc;
    end else if (advance) begin
      // Natural AW-bit overflow gives the 2^AW-1 -> 0 wrap.
      pc_value_next = pc_value_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_value_reg <= AW'(RESET_PC);
    end else begin
      pc_value_reg <= pc_value_next;
    end
  end

  assign pc = pc_value_reg;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: drives the PC to a combinational instruction
//   memory, captures the returned word into the IF/ID register and offers it
//   to decode through a valid/ready handshake. Supports redirect with flush,
//   start gating and halting on an all-zero fetched word.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     start        : leave IDLE and begin fetching
//     imem_addr    : word address to instruction memory (= pc)
//     imem_data    : instruction word returned for imem_addr
//     redirect     : branch/jump taken, load redirect_pc and flush IF/ID
//     redirect_pc  : redirect target
//     id           : IF/ID handshake (master side)
//     halted       : controller is in HALT
//     fetch_count  : words captured since reset, saturating at 0xFFFF
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int AW           = FETCH_AW,
  parameter int DW           = FETCH_DW,
  parameter int RESET_PC     = 0,
  parameter int HALT_ON_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     imem_addr,
  input  logic [DW-1:0]     imem_data,
  input  logic              redirect,
  input  logic [AW-1:0]     redirect_pc,
  fetch_stage_if.master     id,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam logic [DW-1:0] NOP_W   = DW'(NOP_WORD);
  localparam logic          HALT_EN = (HALT_ON_ZERO != 0);

  fetch_state_t  state_reg;
  logic          id_valid_reg;
  logic [DW-1:0] id_instr_reg;
  logic [AW-1:0] id_pc_reg;
  logic [15:0]   fetch_count_reg;

  logic [AW-1:0] pc;
  logic          fetch_en;
  logic          halt_word;
  logic          capture;
  logic          halt_fetch;

  // A fetch happens only when IF/ID is free (empty or being drained) and no
  // redirect is discarding this cycle's word.
  assign fetch_en   = (state_reg == RUN) && (!id_valid_reg || id.id_ready) && !redirect;
  assign halt_word  = HALT_EN && (imem_data == NOP_W);
  assign capture    = fetch_en && !halt_word;
  assign halt_fetch = fetch_en && halt_word;

  pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (capture),
    .pc          (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      id_valid_reg    <= 1'b0;
      id_instr_reg    <= '0;
      id_pc_reg       <= '0;
      fetch_count_reg <= '0;
    end else if (redirect) begin
      // Flush; the PC reload happens in pc_reg. IDLE stays IDLE.
      id_valid_reg <= 1'b0;
      if (state_reg == HALT) begin
        state_reg <= RUN;
      end
    end else begin
      case (state_reg)
        IDLE:    if (start) state_reg <= RUN;
        RUN:     if (halt_fetch) state_reg <= HALT;
        HALT:    state_reg <= HALT;
        default: state_reg <= IDLE;
      endcase

      if (capture) begin
        id_instr_reg <= imem_data;
        id_pc_reg    <= pc;
        id_valid_reg <= 1'b1;
        if (fetch_count_reg != 16'hFFFF) begin
          fetch_count_reg <= fetch_count_reg + 16'd1;
        end
      end else if (id_valid_reg && id.id_ready) begin
        // Covers both a plain drain and a halting fetch that drains IF/ID.
        id_valid_reg <= 1'b0;
      end
    end
  end

  assign imem_addr     = pc;
  assign id.id_valid   = id_valid_reg;
  assign id.id_instr   = id_instr_reg;
  assign id.id_pc      = id_pc_reg;
  assign id.id_pc_next = id_pc_reg + AW'(1);
  assign halted        = (state_reg == HALT);
  assign fetch_count   = fetch_count_reg;

endmodule
